// File: rtl/param_dual_port_ram.sv
// Parametrised simple-dual-port RAM with a registered read port, range checking,
// selectable read-during-write behaviour and a power-up init engine loading mem[i] = i.
module param_dual_port_ram #(
   parameter int DATA_W   = 4,
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 16,
   parameter int RDW_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_err,
   output logic              init_busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {INIT, READY} state_t;

   state_t            state;
   state_t            next_state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] init_word;
   logic              rd_in_range;
   logic              wr_in_range;
   logic              rd_req;
   logic              wr_req;
   logic              same_addr_fwd;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  cnt_idx;

   logic [DATA_W-1:0] mem [DEPTH];

   // The full address is compared against DEPTH so that out-of-range
   // addresses never alias onto a valid word through the truncated index.
   always_comb begin
      next_state    = state;
      init_word     = DATA_W'(cnt);
      rd_in_range   = ({1'b0, rd_addr} < DEPTH_X);
      wr_in_range   = ({1'b0, wr_addr} < DEPTH_X);
      rd_req        = (state == READY) && rd_en;
      wr_req        = (state == READY) && wr_en;
      same_addr_fwd = (RDW_MODE == 1) && wr_req && wr_in_range && (wr_addr == rd_addr);
      rd_idx        = rd_addr[IDX_W-1:0];
      wr_idx        = wr_addr[IDX_W-1:0];
      cnt_idx       = cnt[IDX_W-1:0];
      if ((state == INIT) && (cnt == LAST)) begin
         next_state = READY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= next_state;
         if (state == INIT) begin
            cnt <= cnt + ADDR_W'(1);
         end
      end
   end

   // Storage is deliberately not reset; the init sweep rewrites every word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT) begin
            mem[cnt_idx] <= init_word;
         end else if (wr_req && wr_in_range) begin
            mem[wr_idx] <= wr_data;
         end
      end
   end

   // rd_data keeps its last value on idle cycles; only flags drop back to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req && !rd_in_range;
         wr_err   <= wr_req && !wr_in_range;
         if (rd_req) begin
            if (!rd_in_range) begin
               rd_data <= '0;
            end else if (same_addr_fwd) begin
               rd_data <= wr_data;
            end else begin
               rd_data <= mem[rd_idx];
            end
         end
      end
   end

   assign init_busy = (state == INIT);

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Self-checking bench: two RAM instances (old-data and write-through) share stimulus;
// a behavioural model pushes expected outputs into a queue that is popped after each edge.
module tb_param_dual_port_ram;

   localparam int DW  = 4;
   localparam int AW  = 5;
   localparam int DEP = 16;

   logic          clk;
   logic          rst;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1;
   logic          rd_err0, rd_err1;
   logic          wr_err0, wr_err1;
   logic          init_busy0, init_busy1;

   typedef struct {
      logic          valid;
      logic          err;
      logic          werr;
      logic          busy;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] model [DEP];
   logic [DW-1:0] last0;
   logic [DW-1:0] last1;
   int            init_left;
   int            n_checks;
   int            n_fails;

   param_dual_port_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RDW_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .rd_err(rd_err0), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err0), .init_busy(init_busy0)
   );

   param_dual_port_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RDW_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .rd_err(rd_err1), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_err(wr_err1), .init_busy(init_busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pops the expectation for the edge just taken and compares both instances.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fails++;
         $error("[TB] FAIL %s scoreboard_empty observed=0 expected=1", tag);
         return;
      end
      e = sb.pop_front();
      check1({tag, ".busy0"},  8'(init_busy0), 8'(e.busy));
      check1({tag, ".busy1"},  8'(init_busy1), 8'(e.busy));
      check1({tag, ".valid0"}, 8'(rd_valid0),  8'(e.valid));
      check1({tag, ".valid1"}, 8'(rd_valid1),  8'(e.valid));
      check1({tag, ".rerr0"},  8'(rd_err0),    8'(e.err));
      check1({tag, ".rerr1"},  8'(rd_err1),    8'(e.err));
      check1({tag, ".werr0"},  8'(wr_err0),    8'(e.werr));
      check1({tag, ".werr1"},  8'(wr_err1),    8'(e.werr));
      check1({tag, ".data0"},  8'(rd_data0),   8'(e.d0));
      check1({tag, ".data1"},  8'(rd_data1),   8'(e.d1));
   endtask

   // Computes the expected result of one cycle, drives it, clocks and checks.
   task automatic applyStimulus(input string tag, input logic r, input logic ren, input int raddr,
                                input logic wen, input int waddr, input logic [DW-1:0] wdata);
      exp_t e;
      logic rin;
      logic win;
      int   idx;
      rin = (raddr < DEP);
      win = (waddr < DEP);
      e.valid = 1'b0;
      e.err   = 1'b0;
      e.werr  = 1'b0;
      e.d0    = last0;
      e.d1    = last1;
      if (r) begin
         e.d0 = '0;
         e.d1 = '0;
         init_left = DEP;
      end else if (init_left > 0) begin
         idx = DEP - init_left;
         model[idx] = DW'(idx);
         init_left--;
      end else begin
         e.valid = ren;
         e.err   = ren && !rin;
         e.werr  = wen && !win;
         if (ren) begin
            if (rin) begin
               e.d0 = model[raddr];
               e.d1 = (wen && win && (waddr == raddr)) ? wdata : model[raddr];
            end else begin
               e.d0 = '0;
               e.d1 = '0;
            end
         end
         if (wen && win) model[waddr] = wdata;
      end
      e.busy = (init_left > 0);
      last0 = e.d0;
      last1 = e.d1;
      sb.push_back(e);
      rst     = r;
      rd_en   = ren;
      rd_addr = AW'(raddr);
      wr_en   = wen;
      wr_addr = AW'(waddr);
      wr_data = wdata;
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      init_left = DEP;
      last0     = '0;
      last1     = '0;
      rst       = 1'b1;
      rd_en     = 1'b0;
      rd_addr   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;

      applyStimulus("reset", 1'b1, 1'b0, 0, 1'b0, 0, 4'h0);
      for (int i = 0; i < DEP; i++) applyStimulus("init", 1'b0, 1'b0, 0, 1'b0, 0, 4'h0);

      // Streaming reads of the freshly initialised table.
      for (int i = 0; i < DEP; i++) applyStimulus("stream", 1'b0, 1'b1, i, 1'b0, 0, 4'h0);
      applyStimulus("idle", 1'b0, 1'b0, 0, 1'b0, 0, 4'h0);

      applyStimulus("wr3", 1'b0, 1'b0, 0, 1'b1, 3, 4'hA);
      applyStimulus("rd3", 1'b0, 1'b1, 3, 1'b0, 0, 4'h0);
      applyStimulus("idle", 1'b0, 1'b0, 0, 1'b0, 0, 4'h0);

      applyStimulus("rd16", 1'b0, 1'b1, 16, 1'b0, 0, 4'h0);
      applyStimulus("wr20", 1'b0, 1'b0, 0, 1'b1, 20, 4'hE);
      applyStimulus("rd4", 1'b0, 1'b1, 4, 1'b0, 0, 4'h0);
      applyStimulus("rd31", 1'b0, 1'b1, 31, 1'b1, 16, 4'h9);
      applyStimulus("rd0", 1'b0, 1'b1, 0, 1'b0, 0, 4'h0);

      applyStimulus("rdw5", 1'b0, 1'b1, 5, 1'b1, 5, 4'hC);
      applyStimulus("rd5", 1'b0, 1'b1, 5, 1'b0, 0, 4'h0);
      applyStimulus("rd7wr6", 1'b0, 1'b1, 7, 1'b1, 6, 4'h1);
      applyStimulus("rd6", 1'b0, 1'b1, 6, 1'b0, 0, 4'h0);
      applyStimulus("idle", 1'b0, 1'b0, 0, 1'b0, 0, 4'h0);

      // Reset in the middle of the init sweep, with writes attempted while busy.
      applyStimulus("reset2", 1'b1, 1'b0, 0, 1'b0, 0, 4'h0);
      for (int i = 0; i < 7; i++) applyStimulus("init_a", 1'b0, 1'b1, 2, 1'b1, 2, 4'hF);
      applyStimulus("reset3", 1'b1, 1'b0, 0, 1'b0, 0, 4'h0);
      for (int i = 0; i < DEP; i++) applyStimulus("init_b", 1'b0, 1'b1, 2, 1'b1, 2, 4'hF);
      applyStimulus("rd2", 1'b0, 1'b1, 2, 1'b0, 0, 4'h0);
      applyStimulus("rd3b", 1'b0, 1'b1, 3, 1'b0, 0, 4'h0);
      applyStimulus("rd15", 1'b0, 1'b1, 15, 1'b0, 0, 4'h0);
      applyStimulus("idle", 1'b0, 1'b0, 0, 1'b0, 0, 4'h0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
